bpb_table: RTL
==============

# bpb_table

Parametrised, direct-mapped branch prediction buffer for the dual-issue fetch stage. Each entry holds a valid bit, PC tag, target PC and a 2-bit saturating counter. The table serves PORTS simultaneous combinational lookups and takes one commit-side update per cycle from the branch-resolution stage. It replaces the single-entry, tagless predictor line with a real indexed and tagged table that also stores branch targets.

## Interface
- ENTRIES, 64, number of entries; power of two, ≥ 2; IDX_W = log2(ENTRIES)
- PORTS, 2, number of prediction lanes, ≥ 1
- TAG_W, derived, 30 − IDX_W; tag = pc[31:2+IDX_W]; index = pc[2+IDX_W-1:2]

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  when high, commit updates are blocked
- flush  input  1  invalidates every entry; counters are untouched
- pc_predict  input  PORTS×32  lookup PCs, one per lane
- hit_predict  output  PORTS  lane's entry is valid and its tag matches
- taken_predict  output  PORTS  predicted taken: hit & state[1]
- destpc_predict  output  PORTS×32  stored target on hit, else 0
- wen  input  1  commit update request
- pc_commit  input  32  PC of the resolved branch
- taken_commit  input  1  resolved direction
- destpc_commit  input  32  resolved target

## Operation
- Counter encoding; prediction uses state[1]:
  - 00 = strong not-taken
  - 01 = weak not-taken
  - 10 = weak taken
  - 11 = strong taken
- Counter transitions:
  - taken: 00→01, 01→11, 10→11, 11→11
  - not-taken: 00→00, 01→00, 10→00, 11→10
- Lookup (lane i): purely combinational from table flops.
  - e = table[index(pc_predict[i])]
  - hit = e.valid & (e.tag == tag(pc_predict[i]))
  - taken_predict = hit & e.state[1]
  - destpc_predict = hit ? e.destpc : 0
  - Lanes are independent; two lanes may read the same entry.
- Commit update applies when wen & ~stall & ~flush & ~reset. Let e = table[index(pc_commit)].
  - Hit (valid and tag match): state ← transition(e.state, taken_commit). If taken_commit, destpc ← destpc_commit; otherwise destpc is unchanged.
  - Miss (invalid, or tag mismatch): allocate/overwrite the entry.
    - valid ← 1, tag ← tag(pc_commit), destpc ← destpc_commit.
    - state ← transition(10, taken_commit), i.e. 11 if taken, 00 if not-taken.
- Priority: reset > flush > update.
  - flush clears all valid bits in one cycle, ignores stall, and discards a same-cycle update.
- Only the indexed entry changes on an update; all other entries hold.

## Timing
- Lookup latency is 0 cycles (combinational); an update becomes visible to lookups on the cycle after the edge.
- No bypass: a lookup of the entry being updated in the same cycle returns the pre-update contents.
- Reset (one cycle, synchronous):
  - every valid = 0; every state = 10; tag and destpc = 0.
  - Outputs from the cycle after reset: hit_predict = 0, taken_predict = 0, destpc_predict = 0 on all lanes.
- Reset asserted mid-stream overrides any wen or flush in the same cycle. The first update is accepted on the cycle after reset deasserts.
- Stall held for N cycles drops the commit; there is no queueing. Upstream must hold wen/pc_commit until ~stall.
- Index wrap-around: PCs differing only in tag alias to one entry. The latest commit wins, and the older branch then misses.

## Test plan
- Reset, then lookup 0x00400010 on both lanes → hit = 00, taken = 00, destpc = 0.
- Commit pc = 0x00400010, taken = 1, dest = 0x00400100. Next cycle, lookup on lane 1 → hit = 1, taken = 1, dest = 0x00400100, state = 11. Then two not-taken commits → state 10 then 00, taken_predict 1 then 0; dest stays 0x00400100.
- Counter walk from 00: commits T, T, N, N, T → states 01, 11, 10, 00, 01; taken_predict 0, 1, 1, 0, 0.
- Aliasing (ENTRIES = 64): commit 0x00400010 taken, then 0x00400110 not-taken (same index) → 0x00400010 misses; 0x00400110 hits with state 00.
- Same-cycle wen+flush after populating 4 entries → all hits 0 next cycle, update discarded. wen with stall = 1 for 3 cycles → no change. Releasing stall → update applied.
- Same-cycle lookup and update of one entry → old value seen that cycle, new value the next. Reset asserted together with wen → table stays empty.

Source files
------------

// File: rtl/bpb_table.sv
// bpb_table: direct-mapped, tagged branch prediction buffer.
//   Each entry holds a valid bit, PC tag, target PC and a 2-bit counter.
//   PORTS independent combinational lookups are served from the table flops.
//   One commit-side update per cycle comes from the branch-resolution stage.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   stall              blocks commit updates while high
//   flush              clears every valid bit (counters untouched)
//   pc_predict         PORTS x 32 lookup PCs, lane i at [i*32 +: 32]
//   hit_predict        per-lane valid & tag match
//   taken_predict      per-lane hit & counter[1]
//   destpc_predict     per-lane stored target on hit, else 0
//   wen                commit update request
//   pc_commit          PC of the resolved branch
//   taken_commit       resolved direction
//   destpc_commit      resolved target
module bpb_table #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned PORTS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [PORTS*32-1:0]   pc_predict,
  output logic [PORTS-1:0]      hit_predict,
  output logic [PORTS-1:0]      taken_predict,
  output logic [PORTS*32-1:0]   destpc_predict,
  input  logic                  wen,
  input  logic [31:0]           pc_commit,
  input  logic                  taken_commit,
  input  logic [31:0]           destpc_commit
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      destpc;
    logic [1:0]       state;
  } entry_t;

  entry_t tbl [ENTRIES];

  // 2-bit counter: taken 00->01, 01/10/11->11; not-taken 11->10, else ->00
  function automatic logic [1:0] next_state(input logic [1:0] s, input logic t);
    if (t) begin
      return (s == 2'b00) ? 2'b01 : 2'b11;
    end else begin
      return (s == 2'b11) ? 2'b10 : 2'b00;
    end
  endfunction

  // Byte-offset bits never participate in indexing or tagging
  logic [2*PORTS-1:0] unused_pred_bits;
  logic [1:0]         unused_commit_bits;
  assign unused_commit_bits = pc_commit[1:0];

  // Per-lane combinational lookup
  for (genvar i = 0; i < PORTS; i++) begin : g_lane
    logic [31:0]      pc;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tg;
    entry_t           e;
    logic             hit;

    assign pc  = pc_predict[i*32 +: 32];
    assign idx = pc[2+IDX_W-1:2];
    assign tg  = pc[31:2+IDX_W];
    assign e   = tbl[idx];
    assign hit = e.valid && (e.tag == tg);

    assign unused_pred_bits[2*i +: 2]   = pc[1:0];
    assign hit_predict[i]               = hit;
    assign taken_predict[i]             = hit & e.state[1];
    assign destpc_predict[i*32 +: 32]   = hit ? e.destpc : 32'h0;
  end

  // Commit-side entry decode
  logic [IDX_W-1:0] c_idx;
  logic [TAG_W-1:0] c_tag;
  entry_t           c_e;
  logic             c_hit;

  assign c_idx = pc_commit[2+IDX_W-1:2];
  assign c_tag = pc_commit[31:2+IDX_W];
  assign c_e   = tbl[c_idx];
  assign c_hit = c_e.valid && (c_e.tag == c_tag);

  // Table state: reset > flush > update; only the indexed entry changes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < ENTRIES; k++) begin
        tbl[k] <= '{valid: 1'b0, tag: '0, destpc: 32'h0, state: 2'b10};
      end
    end else if (flush) begin
      for (int unsigned k = 0; k < ENTRIES; k++) begin
        tbl[k].valid <= 1'b0;
      end
    end else if (wen && !stall) begin
      if (c_hit) begin
        tbl[c_idx].state <= next_state(c_e.state, taken_commit);
        if (taken_commit) begin
          tbl[c_idx].destpc <= destpc_commit;
        end
      end else begin
        // Allocation starts from weak-taken, landing on 11 or 00
        tbl[c_idx] <= '{valid: 1'b1, tag: c_tag, destpc: destpc_commit,
                        state: next_state(2'b10, taken_commit)};
      end
    end
  end

endmodule
